// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU fetch/execute controllers.
// Covers opcodes, ALU encodings, IR field positions and the controller state encoding.
package cpu_ctrl_pkg;

  localparam int unsigned IR_W     = 16;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned TIMER_W  = 8;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned RS_LSB   = 4;
  localparam int unsigned ADDR_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR    = 4'h6;
  localparam logic [OPC_W-1:0] OP_LDI   = 4'h7;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'h8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DECODE, ST_MEM_ADDR, ST_MEM_WAIT, ST_LD_XFER, ST_ST_DATA,
    ST_ALU_A, ST_ALU_B, ST_ALU_WB, ST_LDI, ST_JUMP, ST_DONE
  } ctrl_state_e;

  // ALU opcodes 3..6 map directly onto the 2-bit ALU function code.
  function automatic alu_op_e alu_op_of(input logic [OPC_W-1:0] opc);
    return alu_op_e'(2'(opc - OP_ADD));
  endfunction

endpackage

// File: rtl/exec_fsm_if.sv
// Execute-controller bus: fetch handshake, IR and memory ack in; datapath strobes out.
interface exec_fsm_if;
  import cpu_ctrl_pkg::*;

  logic             start;
  logic [IR_W-1:0]  ir;
  logic             mfc;
  logic             ir_addr_out;
  logic             mar_en;
  logic             mbr_in_en;
  logic             mbr_out_en;
  logic             rw;
  logic             enable;
  logic [REG_W-1:0] reg_sel;
  logic             reg_out;
  logic             reg_in;
  logic             alu_a_en;
  logic [1:0]       alu_op;
  logic             alu_res_out;
  logic             pc_in;
  logic             done;
  logic             err;

  modport master (
    input  start, ir, mfc,
    output ir_addr_out, mar_en, mbr_in_en, mbr_out_en, rw, enable, reg_sel,
           reg_out, reg_in, alu_a_en, alu_op, alu_res_out, pc_in, done, err
  );

  modport slave (
    output start, ir, mfc,
    input  ir_addr_out, mar_en, mbr_in_en, mbr_out_en, rw, enable, reg_sel,
           reg_out, reg_in, alu_a_en, alu_op, alu_res_out, pc_in, done, err
  );

endinterface

// File: rtl/mfc_timer.sv
// Memory-wait watchdog: counts stalled MEM_WAIT cycles and flags when TIMEOUT is reached.
module mfc_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TIMER_W'(TIMEOUT));

endmodule

// File: rtl/exec_fsm.sv
// Instruction execute controller: decodes the latched IR and sequences Moore datapath strobes.
// Strobes decode only from state and latched IR, so an async reset clears them at once.
module exec_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MFC_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  exec_fsm_if.master bus
);

  ctrl_state_e      state_q, state_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic             err_q, err_d;
  logic             tmr_clr, tmr_inc, tmr_expired;
  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] rd, rs;
  logic             unused_ir_lo;

  assign opc          = ir_q[OPC_LSB +: OPC_W];
  assign rd           = ir_q[RD_LSB +: REG_W];
  assign rs           = ir_q[RS_LSB +: REG_W];
  assign unused_ir_lo = ^ir_q[ADDR_LSB +: 4];

  mfc_timer #(.TIMEOUT(MFC_TIMEOUT)) u_mfc_timer (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    err_d           = err_q;
    tmr_clr         = 1'b1;
    tmr_inc         = 1'b0;
    bus.ir_addr_out = 1'b0;
    bus.mar_en      = 1'b0;
    bus.mbr_in_en   = 1'b0;
    bus.mbr_out_en  = 1'b0;
    bus.rw          = 1'b0;
    bus.enable      = 1'b0;
    bus.reg_sel     = '0;
    bus.reg_out     = 1'b0;
    bus.reg_in      = 1'b0;
    bus.alu_a_en    = 1'b0;
    bus.alu_op      = 2'b00;
    bus.alu_res_out = 1'b0;
    bus.pc_in       = 1'b0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ir_d    = bus.ir;
          err_d   = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opc)
          OP_NOP:                         state_d = ST_DONE;
          OP_LOAD:                        state_d = ST_MEM_ADDR;
          OP_STORE:                       state_d = ST_ST_DATA;
          OP_ADD, OP_SUB, OP_AND, OP_OR:  state_d = ST_ALU_A;
          OP_LDI:                         state_d = ST_LDI;
          OP_JMP:                         state_d = ST_JUMP;
          default: begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        bus.ir_addr_out = 1'b1;
        bus.mar_en      = 1'b1;
        state_d         = ST_MEM_WAIT;
      end
      // mfc takes priority over an expiring timer on the same cycle.
      ST_MEM_WAIT: begin
        bus.enable = 1'b1;
        bus.rw     = (opc == OP_LOAD);
        tmr_clr    = 1'b0;
        if (bus.mfc) begin
          state_d = (opc == OP_LOAD) ? ST_LD_XFER : ST_DONE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_LD_XFER: begin
        bus.mbr_out_en = 1'b1;
        bus.reg_in     = 1'b1;
        bus.reg_sel    = rd;
        state_d        = ST_DONE;
      end
      ST_ST_DATA: begin
        bus.reg_out   = 1'b1;
        bus.reg_sel   = rd;
        bus.mbr_in_en = 1'b1;
        state_d       = ST_MEM_ADDR;
      end
      ST_ALU_A: begin
        bus.reg_out  = 1'b1;
        bus.reg_sel  = rd;
        bus.alu_a_en = 1'b1;
        state_d      = ST_ALU_B;
      end
      ST_ALU_B: begin
        bus.reg_out = 1'b1;
        bus.reg_sel = rs;
        bus.alu_op  = alu_op_of(opc);
        state_d     = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        bus.alu_res_out = 1'b1;
        bus.reg_in      = 1'b1;
        bus.reg_sel     = rd;
        bus.alu_op      = alu_op_of(opc);
        state_d         = ST_DONE;
      end
      ST_LDI: begin
        bus.ir_addr_out = 1'b1;
        bus.reg_in      = 1'b1;
        bus.reg_sel     = rd;
        state_d         = ST_DONE;
      end
      ST_JUMP: begin
        bus.ir_addr_out = 1'b1;
        bus.pc_in       = 1'b1;
        state_d         = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_fsm.sv
// Scoreboard bench for exec_fsm: stimulus queues expected strobe vectors with cycle stamps,
// a negedge monitor pops and compares every non-idle output vector.
module tb_exec_fsm;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic       ir_addr_out;
    logic       mar_en;
    logic       mbr_in_en;
    logic       mbr_out_en;
    logic       rw;
    logic       enable;
    logic [3:0] reg_sel;
    logic       reg_out;
    logic       reg_in;
    logic       alu_a_en;
    logic [1:0] alu_op;
    logic       alu_res_out;
    logic       pc_in;
    logic       done;
    logic       err;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   base  = 0;
  exp_t q[$];
  exp_t mon_x;
  obs_t obs;

  exec_fsm_if bus ();

  exec_fsm #(.MFC_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {bus.ir_addr_out, bus.mar_en, bus.mbr_in_en, bus.mbr_out_en, bus.rw, bus.enable,
                bus.reg_sel, bus.reg_out, bus.reg_in, bus.alu_a_en, bus.alu_op,
                bus.alu_res_out, bus.pc_in, bus.done, bus.err};

  function automatic obs_t f_mem_addr();
    obs_t o = '0; o.ir_addr_out = 1'b1; o.mar_en = 1'b1; return o;
  endfunction
  function automatic obs_t f_wait(input logic rw);
    obs_t o = '0; o.enable = 1'b1; o.rw = rw; return o;
  endfunction
  function automatic obs_t f_ld_xfer(input logic [3:0] rd);
    obs_t o = '0; o.mbr_out_en = 1'b1; o.reg_in = 1'b1; o.reg_sel = rd; return o;
  endfunction
  function automatic obs_t f_st_data(input logic [3:0] rd);
    obs_t o = '0; o.reg_out = 1'b1; o.reg_sel = rd; o.mbr_in_en = 1'b1; return o;
  endfunction
  function automatic obs_t f_alu_a(input logic [3:0] rd);
    obs_t o = '0; o.reg_out = 1'b1; o.reg_sel = rd; o.alu_a_en = 1'b1; return o;
  endfunction
  function automatic obs_t f_alu_b(input logic [3:0] rs, input logic [1:0] op);
    obs_t o = '0; o.reg_out = 1'b1; o.reg_sel = rs; o.alu_op = op; return o;
  endfunction
  function automatic obs_t f_alu_wb(input logic [3:0] rd, input logic [1:0] op);
    obs_t o = '0; o.alu_res_out = 1'b1; o.reg_in = 1'b1; o.reg_sel = rd; o.alu_op = op; return o;
  endfunction
  function automatic obs_t f_ldi(input logic [3:0] rd);
    obs_t o = '0; o.ir_addr_out = 1'b1; o.reg_in = 1'b1; o.reg_sel = rd; return o;
  endfunction
  function automatic obs_t f_jump();
    obs_t o = '0; o.ir_addr_out = 1'b1; o.pc_in = 1'b1; return o;
  endfunction
  function automatic obs_t f_done(input logic err);
    obs_t o = '0; o.done = 1'b1; o.err = err; return o;
  endfunction

  // e is the edge number counted from the edge that samples start (edge 1).
  task automatic push(input int e, input obs_t o);
    exp_t x;
    x.cyc = base + e;
    x.o   = o;
    q.push_back(x);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at cyc=%0d", nm, got, want, cyc);
    end
  endtask

  // Issue one instruction; mfc is high for the cycle after edge mfc_at (0 = never).
  task automatic run(input logic [15:0] ir_v, input int mfc_at, input int n_edges);
    bus.ir    = ir_v;
    bus.start = 1'b1;
    bus.mfc   = 1'b0;
    for (int e = 1; e <= n_edges + 1; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        bus.start = 1'b0;
        bus.ir    = 16'h0F0F;
      end
      bus.mfc = (e == mfc_at);
    end
    bus.mfc = 1'b0;
    check("pending_expect", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (reset && obs != '0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out cyc=%0d got=%h want=none", cyc, obs);
      end else begin
        mon_x = q.pop_front();
        if (mon_x.cyc != cyc || mon_x.o != obs) begin
          bad++;
          $display("FAIL out_vec got cyc=%0d vec=%h want cyc=%0d vec=%h",
                   cyc, obs, mon_x.cyc, mon_x.o);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.ir    = '0;
    bus.mfc   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outs", 32'(obs), 32'd0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // ADD r1,r2
    base = cyc;
    push(2, f_alu_a(4'd1)); push(3, f_alu_b(4'd2, 2'b00));
    push(4, f_alu_wb(4'd1, 2'b00)); push(5, f_done(1'b0));
    run(16'h3120, 0, 5);

    // OR r4,r5
    base = cyc;
    push(2, f_alu_a(4'd4)); push(3, f_alu_b(4'd5, 2'b11));
    push(4, f_alu_wb(4'd4, 2'b11)); push(5, f_done(1'b0));
    run(16'h6450, 0, 5);

    // LOAD r3,[0x40], mfc after 3 wait cycles
    base = cyc;
    push(2, f_mem_addr());
    for (int k = 3; k <= 6; k++) push(k, f_wait(1'b1));
    push(7, f_ld_xfer(4'd3)); push(8, f_done(1'b0));
    run(16'h1340, 6, 8);

    // STORE r5 with one wait cycle
    base = cyc;
    push(2, f_st_data(4'd5)); push(3, f_mem_addr());
    push(4, f_wait(1'b0)); push(5, f_wait(1'b0)); push(6, f_done(1'b0));
    run(16'h2540, 5, 6);

    // STORE timeout: five wait cycles then error
    base = cyc;
    push(2, f_st_data(4'd5)); push(3, f_mem_addr());
    for (int k = 4; k <= 8; k++) push(k, f_wait(1'b0));
    push(9, f_done(1'b1));
    run(16'h2540, 0, 9);

    // STORE with mfc on the timeout cycle: no error
    base = cyc;
    push(2, f_st_data(4'd5)); push(3, f_mem_addr());
    for (int k = 4; k <= 8; k++) push(k, f_wait(1'b0));
    push(9, f_done(1'b0));
    run(16'h2540, 8, 9);

    // Illegal opcode, then JMP
    base = cyc;
    push(2, f_done(1'b1));
    run(16'hF000, 0, 2);
    base = cyc;
    push(2, f_jump()); push(3, f_done(1'b0));
    run(16'h8012, 0, 3);

    // LDI r10
    base = cyc;
    push(2, f_ldi(4'hA)); push(3, f_done(1'b0));
    run(16'h7A5C, 0, 3);

    // Reset while LOAD sits in MEM_WAIT
    base = cyc;
    push(2, f_mem_addr()); push(3, f_wait(1'b1));
    bus.ir    = 16'h1340;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_enable", 32'(bus.enable), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("reset_async_outs", 32'(obs), 32'd0);
    check("reset_pending", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // NOP after reset
    base = cyc;
    push(2, f_done(1'b0));
    run(16'h0000, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
